// File: rtl/cv32e40p_pkg.sv
// ============================================================================
//  Module   : cv32e40p_pkg
//  Purpose  : Shared types for the load/store unit: access-size encoding,
//             LSU FSM state encoding and the misalignment predicate.
//  Macro    : CV32E40P_LSU_MISALIGNED_EN adds the second-transaction states
//             used when a misaligned access is split in two.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_GNT     = 3'd1,
        WAIT_RVALID  = 3'd2
`ifdef CV32E40P_LSU_MISALIGNED_EN
        ,
        WAIT_GNT2    = 3'd3,
        WAIT_RVALID2 = 3'd4
`endif
    } lsu_state_e;

    // An access is misaligned when it crosses a word boundary. The unused
    // size code 2'b11 is handled as a word everywhere.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] offset);
        return ((size == LSU_HALF) && (offset == 2'd3)) ||
               (size[1] && (offset != 2'd0));
    endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40p_lsu_align.sv
// ============================================================================
//  Module   : cv32e40p_lsu_align
//  Purpose  : Combinational lane steering for the LSU.
//             be        - byte enables over two words (upper nibble = lanes
//                         spilling into the next word)
//             wdata_sh  - store data shifted onto its byte lanes, 64 bits
//             rdata_ext - load data extracted from a 64-bit window
//                         ({next word, this word}) and extended
//  Ports    : size, offset, sign_ext, wdata, rdata -> be, wdata_sh, rdata_ext
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_lsu_align
    import cv32e40p_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [3:0]  be_base;
    logic [31:0] rdata_sh;

    always_comb begin
        case (size)
            LSU_BYTE: be_base = 4'b0001;
            LSU_HALF: be_base = 4'b0011;
            default:  be_base = 4'b1111;
        endcase
    end

    assign be       = {4'b0000, be_base} << offset;
    assign wdata_sh = {32'h0, wdata} << {offset, 3'b000};
    // Bytes of a split load sit in the 64-bit window, so one right shift
    // both aligns and merges the two halves.
    assign rdata_sh = 32'(rdata >> {offset, 3'b000});

    always_comb begin
        case (size)
            LSU_BYTE: rdata_ext = {{24{sign_ext & rdata_sh[7]}},  rdata_sh[7:0]};
            LSU_HALF: rdata_ext = {{16{sign_ext & rdata_sh[15]}}, rdata_sh[15:0]};
            default:  rdata_ext = rdata_sh;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cv32e40p_load_store_unit.sv
// ============================================================================
//  Module   : cv32e40p_load_store_unit
//  Purpose  : Data-memory port. Accepts one load/store from EX, runs it on the
//             OBI-style bus with a single outstanding transaction and returns
//             registered, aligned and extended load data.
//  Ports    : lsu_*_i / lsu_*_o  - request from ID/EX, completion to EX
//             data_*             - OBI-style data bus (all outputs registered)
//  Macro    : CV32E40P_LSU_MISALIGNED_EN - split misaligned accesses into two
//             bus transactions; otherwise they are rejected with a one-cycle
//             lsu_err_misaligned_o pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_load_store_unit
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_en_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_sign_ext_i,
    input  logic [ADDR_W-1:0] lsu_operand_a_i,
    input  logic [ADDR_W-1:0] lsu_operand_b_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_ready_o,
    output logic              lsu_rvalid_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_misaligned_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i
);

    lsu_state_e        state;
    logic              idle;
    logic              accept;
    logic              misaligned;
    logic              reject;
    logic [ADDR_W-1:0] ea;

    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              sign_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              req_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              rvalid_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [1:0]        al_size;
    logic [1:0]        al_off;
    logic              al_sign;
    logic [63:0]       al_rdata_in;
    logic [7:0]        al_be;
    logic [63:0]       al_wdata;
    logic [31:0]       al_rdata;

`ifdef CV32E40P_LSU_MISALIGNED_EN
    logic              split_q;
    logic [3:0]        be2_q;
    logic [31:0]       wdata2_q;
    logic [31:0]       rdata_lo_q;
`endif

    assign ea         = lsu_operand_a_i + lsu_operand_b_i;
    assign idle       = (state == IDLE);
    assign accept     = lsu_en_i & idle;
    assign misaligned = lsu_misaligned(lsu_size_i, ea[1:0]);

`ifdef CV32E40P_LSU_MISALIGNED_EN
    assign reject      = 1'b0;
    assign al_rdata_in = (state == WAIT_RVALID2) ? {data_rdata_i, rdata_lo_q}
                                                 : {32'h0, data_rdata_i};
`else
    assign reject      = misaligned;
    assign al_rdata_in = {32'h0, data_rdata_i};

    // Spill-over lanes only matter when accesses are split.
    logic unused_split_lanes;
    assign unused_split_lanes = ^{al_be[7:4], al_wdata[63:32]};
`endif

    // The aligner is shared: in IDLE it steers the incoming request onto
    // byte lanes, while busy it extracts load data for the captured request.
    assign al_size = idle ? lsu_size_i     : size_q;
    assign al_off  = idle ? ea[1:0]        : off_q;
    assign al_sign = idle ? lsu_sign_ext_i : sign_q;

    cv32e40p_lsu_align u_align (
        .size      (al_size),
        .offset    (al_off),
        .sign_ext  (al_sign),
        .wdata     (lsu_wdata_i),
        .rdata     (al_rdata_in),
        .be        (al_be),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            sign_q     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
`ifdef CV32E40P_LSU_MISALIGNED_EN
            split_q    <= 1'b0;
            be2_q      <= 4'b0000;
            wdata2_q   <= 32'h0;
            rdata_lo_q <= 32'h0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            state   <= WAIT_GNT;
                            req_q   <= 1'b1;
                            addr_q  <= {ea[ADDR_W-1:2], 2'b00};
                            we_q    <= lsu_we_i;
                            be_q    <= al_be[3:0];
                            wdata_q <= al_wdata[31:0];
                            size_q  <= lsu_size_i;
                            off_q   <= ea[1:0];
                            sign_q  <= lsu_sign_ext_i;
`ifdef CV32E40P_LSU_MISALIGNED_EN
                            split_q  <= misaligned;
                            be2_q    <= al_be[7:4];
                            wdata2_q <= al_wdata[63:32];
`endif
                        end
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) begin
                        req_q <= 1'b0;
                        state <= WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
`ifdef CV32E40P_LSU_MISALIGNED_EN
                        if (split_q) begin
                            // Second half: next word (wraps at the top of
                            // the address space), remaining low lanes.
                            state      <= WAIT_GNT2;
                            req_q      <= 1'b1;
                            addr_q     <= addr_q + ADDR_W'(4);
                            be_q       <= be2_q;
                            wdata_q    <= wdata2_q;
                            rdata_lo_q <= data_rdata_i;
                        end else
`endif
                        begin
                            state    <= IDLE;
                            rvalid_q <= 1'b1;
                            rdata_q  <= we_q ? 32'h0 : al_rdata;
                        end
                    end
                end
`ifdef CV32E40P_LSU_MISALIGNED_EN
                WAIT_GNT2: begin
                    if (data_gnt_i) begin
                        req_q <= 1'b0;
                        state <= WAIT_RVALID2;
                    end
                end
                WAIT_RVALID2: begin
                    if (data_rvalid_i) begin
                        state    <= IDLE;
                        rvalid_q <= 1'b1;
                        rdata_q  <= we_q ? 32'h0 : al_rdata;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_ready_o          = idle;
    assign lsu_rvalid_o         = rvalid_q;
    assign lsu_rdata_o          = rdata_q;
    assign lsu_err_misaligned_o = err_q;
    assign data_req_o           = req_q;
    assign data_addr_o          = addr_q;
    assign data_we_o            = we_q;
    assign data_be_o            = be_q;
    assign data_wdata_o         = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_load_store_unit.sv
// ============================================================================
//  Module   : tb_cv32e40p_load_store_unit
//  Purpose  : Directed bench for cv32e40p_load_store_unit. Stimulus pushes
//             expected bus transactions and completions into queues; a
//             monitor pops and compares whenever the DUT grants a bus
//             request, completes, or reports a misaligned access. A small
//             bus responder supplies gnt/rvalid with programmable delays.
//  Macro    : CV32E40P_LSU_MISALIGNED_EN selects split vs. reject outcomes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_en_i, lsu_we_i, lsu_sign_ext_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_operand_a_i, lsu_operand_b_i, lsu_wdata_i;
    logic        lsu_ready_o, lsu_rvalid_o, lsu_err_misaligned_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    cv32e40p_load_store_unit #(.ADDR_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .lsu_en_i             (lsu_en_i),
        .lsu_we_i             (lsu_we_i),
        .lsu_size_i           (lsu_size_i),
        .lsu_sign_ext_i       (lsu_sign_ext_i),
        .lsu_operand_a_i      (lsu_operand_a_i),
        .lsu_operand_b_i      (lsu_operand_b_i),
        .lsu_wdata_i          (lsu_wdata_i),
        .lsu_ready_o          (lsu_ready_o),
        .lsu_rvalid_o         (lsu_rvalid_o),
        .lsu_rdata_o          (lsu_rdata_o),
        .lsu_err_misaligned_o (lsu_err_misaligned_o),
        .data_req_o           (data_req_o),
        .data_gnt_i           (data_gnt_i),
        .data_addr_o          (data_addr_o),
        .data_we_o            (data_we_o),
        .data_be_o            (data_be_o),
        .data_wdata_o         (data_wdata_o),
        .data_rvalid_i        (data_rvalid_i),
        .data_rdata_i         (data_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
    } rsp_t;

    bus_t        bq[$];
    rsp_t        sq[$];
    logic [31:0] rq[$];

    int n_cmp = 0;
    int n_bad = 0;

    int gnt_delay = 0;
    int rv_delay  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        bus_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        bq.push_back(b);
    endtask

    task automatic push_rsp(input bit is_err, input logic [31:0] rd);
        rsp_t r;
        r.is_err = is_err; r.rdata = rd;
        sq.push_back(r);
    endtask

    // Bus responder: grant after gnt_delay request cycles, rvalid rv_delay
    // cycles after the grant cycle. It deliberately ignores rst so that a
    // response can arrive late, after a reset.
    initial begin
        bit pend;
        int wcnt, rvcnt;
        pend = 0; wcnt = 0; rvcnt = 0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            data_rvalid_i = 1'b0;
            if (data_gnt_i) begin
                data_gnt_i = 1'b0;
                pend  = 1;
                rvcnt = rv_delay;
                wcnt  = 0;
            end else if (!data_req_o) begin
                wcnt = 0;
            end else if (!pend) begin
                if (wcnt >= gnt_delay) data_gnt_i = 1'b1;
                else wcnt++;
            end
            if (pend) begin
                if (rvcnt == 0) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = (rq.size() > 0) ? rq.pop_front() : 32'h0;
                    pend = 0;
                end else begin
                    rvcnt--;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit          held;
        bus_t        h, e;
        rsp_t        r;
        held = 0;
        forever begin
            @(negedge clk);
            if (rst || !data_req_o) begin
                held = 0;
            end else begin
                if (held) begin
                    check("hold_addr",  data_addr_o,  h.addr);
                    check("hold_be",    data_be_o,    h.be);
                    check("hold_we",    data_we_o,    h.we);
                    check("hold_wdata", data_wdata_o, h.wdata);
                end
                held = 1;
                h.addr = data_addr_o; h.be = data_be_o; h.we = data_we_o; h.wdata = data_wdata_o;
                if (data_gnt_i) begin
                    held = 0;
                    if (bq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL bus_unexpected: got addr %h be %b, expected no transaction", data_addr_o, data_be_o);
                    end else begin
                        e = bq.pop_front();
                        check("bus_addr",  data_addr_o,  e.addr);
                        check("bus_be",    data_be_o,    e.be);
                        check("bus_we",    data_we_o,    e.we);
                        check("bus_wdata", data_wdata_o, e.wdata);
                    end
                end
            end
            if (lsu_rvalid_o || lsu_err_misaligned_o) begin
                if (sq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: got rvalid %b err %b rdata %h, expected none",
                             lsu_rvalid_o, lsu_err_misaligned_o, lsu_rdata_o);
                end else begin
                    r = sq.pop_front();
                    check("rsp_err",    lsu_err_misaligned_o, r.is_err);
                    check("rsp_rvalid", lsu_rvalid_o, !r.is_err);
                    if (!r.is_err) check("rsp_rdata", lsu_rdata_o, r.rdata);
                end
            end
        end
    end

    // Drive a request from posedge+1 until it is accepted; returns at
    // posedge+1 of the accepting edge (start of cycle 1).
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd);
        int n;
        lsu_en_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sgn;
        lsu_operand_a_i = a; lsu_operand_b_i = b; lsu_wdata_i = wd;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (lsu_ready_o) break;
            n++;
            if (n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL issue_timeout: got ready 0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk); #1;
        lsu_en_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            if (bq.size() == 0 && sq.size() == 0 && lsu_ready_o) break;
            n++;
            if (n > 300) begin
                n_cmp++; n_bad++;
                $display("FAIL done_timeout: got %0d bus / %0d rsp pending, expected 0", bq.size(), sq.size());
                bq.delete(); sq.delete();
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        lsu_en_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
        lsu_operand_a_i = 32'h0; lsu_operand_b_i = 32'h0; lsu_wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  lsu_ready_o, 1'b1);
        check("rst_req",    data_req_o, 1'b0);
        check("rst_rvalid", lsu_rvalid_o, 1'b0);
        check("rst_err",    lsu_err_misaligned_o, 1'b0);
        check("rst_addr",   data_addr_o, 32'h0);
        check("rst_be",     data_be_o, 4'h0);
        check("rst_wdata",  data_wdata_o, 32'h0);
        check("rst_rdata",  lsu_rdata_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word load, zero-wait bus, 3-cycle latency.
        push_bus(32'h0000_1004, 4'b1111, 1'b0, 32'h0);
        push_rsp(0, 32'hDEAD_BEEF);
        rq.push_back(32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h4, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("lat_cycle2", lsu_rvalid_o, 1'b0);
        @(negedge clk);
        check("lat_cycle3", lsu_rvalid_o, 1'b1);
        wait_done();

        // Byte load at offset 3, signed then unsigned.
        push_bus(32'h0000_2000, 4'b1000, 1'b0, 32'h0);
        push_rsp(0, 32'hFFFF_FF80);
        rq.push_back(32'h8000_0000);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_2000, 32'h3, 32'h0);
        wait_done();
        push_bus(32'h0000_2000, 4'b1000, 1'b0, 32'h0);
        push_rsp(0, 32'h0000_0080);
        rq.push_back(32'h8000_0000);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h3, 32'h0);
        wait_done();

        // Signed half load at offset 1.
        push_bus(32'h0000_0010, 4'b0110, 1'b0, 32'h0);
        push_rsp(0, 32'hFFFF_ABCD);
        rq.push_back(32'h00AB_CD00);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h1, 32'h0);
        wait_done();

        // Half store at offset 2 with two grant wait cycles; rdata forced 0.
        gnt_delay = 2;
        push_bus(32'h0000_3000, 4'b1100, 1'b1, 32'h1234_0000);
        push_rsp(0, 32'h0);
        rq.push_back(32'hFFFF_FFFF);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_3000, 32'h2, 32'h0000_1234);
        wait_done();
        gnt_delay = 0;

        // Byte store at offset 1.
        push_bus(32'h0000_0040, 4'b0010, 1'b1, 32'h0000_A500);
        push_rsp(0, 32'h0);
        rq.push_back(32'h1234_5678);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'h1, 32'h0000_00A5);
        wait_done();

        // Misaligned word load at 0xFFFFFFFE and half store at 0x13.
`ifdef CV32E40P_LSU_MISALIGNED_EN
        push_bus(32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0);
        push_bus(32'h0000_0000, 4'b0011, 1'b0, 32'h0);
        push_rsp(0, 32'hDDCC_BBAA);
        rq.push_back(32'hBBAA_0000);
        rq.push_back(32'h0000_DDCC);
`else
        push_rsp(1, 32'h0);
`endif
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0000_000E, 32'h0);
        wait_done();
`ifdef CV32E40P_LSU_MISALIGNED_EN
        push_bus(32'h0000_0010, 4'b1000, 1'b1, 32'hEF00_0000);
        push_bus(32'h0000_0014, 4'b0001, 1'b1, 32'h0000_00BE);
        push_rsp(0, 32'h0);
        rq.push_back(32'h0);
        rq.push_back(32'h0);
`else
        push_rsp(1, 32'h0);
`endif
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h3, 32'h0000_BEEF);
        wait_done();

        // Reset in WAIT_RVALID; the late response must be dropped.
        rv_delay = 4;
        push_bus(32'h0000_4000, 4'b1111, 1'b0, 32'h0);
        rq.push_back(32'hCAFE_F00D);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        #2;
        check("rst_rv_req",   data_req_o, 1'b0);
        check("rst_rv_ready", lsu_ready_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_rv_ready_after", lsu_ready_o, 1'b1);
        check("rst_rv_rdata",       lsu_rdata_o, 32'h0);
        rv_delay = 0;
        wait_done();

        // Reset in WAIT_GNT drops the request without a clock edge.
        gnt_delay = 50;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'h0);
        #2;
        check("rst_gnt_req_before", data_req_o, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_gnt_req_after", data_req_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        gnt_delay = 0;
        wait_done();

        // Request held high while busy: one transaction per completion,
        // the next accept happens in the completion cycle.
        begin
            int n;
            push_bus(32'h0000_5000, 4'b1111, 1'b0, 32'h0);
            push_bus(32'h0000_5000, 4'b1111, 1'b0, 32'h0);
            push_rsp(0, 32'h1111_1111);
            push_rsp(0, 32'h2222_2222);
            rq.push_back(32'h1111_1111);
            rq.push_back(32'h2222_2222);
            lsu_en_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_sign_ext_i = 1'b0;
            lsu_operand_a_i = 32'h0000_5000; lsu_operand_b_i = 32'h0; lsu_wdata_i = 32'h0;
            n = 0;
            while (1) begin
                @(negedge clk);
                if (lsu_rvalid_o) break;
                n++;
                if (n > 100) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b2b_timeout: got no rvalid in %0d cycles, expected one", n);
                    break;
                end
            end
            check("b2b_ready_in_rvalid_cycle", lsu_ready_o, 1'b1);
            @(posedge clk); #1;
            lsu_en_i = 1'b0;
            @(negedge clk);
            check("b2b_req_next_cycle", data_req_o, 1'b1);
            wait_done();
        end

        check("left_bus", bq.size(), 0);
        check("left_rsp", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
